mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MIPS pipeline MEM stage: consumer end of the EX/MEM bus produced by the execute stage.
//  Drives a handshaked data-memory port, resolves branch (PCSrc), loads the MEM/WB latch.
//  Stalls upstream stages while a load/store waits for memory acknowledge.
// PARAMETERS
//  DW       32  data/address width
//  TIMEOUT  15  max ACCESS cycles without dmem_ack before abort (4-bit counter)
// PORTS
//  clk              in   1   rising-edge clock
//  reset            in   1   asynchronous, active-low reset
//  wb_ctlout        in   2   {RegWrite, MemtoReg} from EX/MEM
//  m_ctlout         in   3   {Branch, MemRead, MemWrite} from EX/MEM
//  alu_result       in   DW  ALU result; memory byte address
//  rdata2out        in   DW  store data
//  add_result       in   DW  branch target
//  zero             in   1   ALU zero flag
//  five_bit_muxout  in   5   destination register
//  dmem_req         out  1   memory request, held until ack
//  dmem_we          out  1   1 = write
//  dmem_addr        out  DW  word-aligned address
//  dmem_wdata       out  DW  write data
//  dmem_ack         in   1   memory done (single cycle)
//  dmem_rdata       in   DW  read data, valid with dmem_ack
//  mem_stall        out  1   freeze PC/IF/ID/ID-EX/EX-MEM
//  pc_src           out  1   take branch
//  branch_target    out  DW  = add_result
//  wb_ctl           out  2   MEM/WB control
//  read_data        out  DW  MEM/WB load data
//  mem_alu_result   out  DW  MEM/WB ALU result
//  mem_write_reg    out  5   MEM/WB destination
//  align_err        out  1   sticky: misaligned access seen
//  bus_err          out  1   sticky: access timed out
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE; all outputs and MEM/WB regs 0; dmem_req drops at once.
//  - States: IDLE, ACCESS. memop = MemRead|MemWrite.
//  - IDLE, no memop: MEM/WB loads inputs each edge (1-cycle latency), read_data <= 0.
//  - IDLE, memop, alu_result[1:0]==0: mem_stall=1 (combinational) same cycle; next edge -> ACCESS,
//    dmem_req<=1, dmem_we<=MemWrite, addr/wdata/dest/wb_ctl latched; MEM/WB loads bubble (wb_ctl=00).
//  - MemRead & MemWrite both set: treated as write; read_data <= 0.
//  - ACCESS: dmem_req/addr/we/wdata stable; mem_stall=1 except on the ack cycle.
//    ack cycle: mem_stall=0; edge loads MEM/WB from latched fields, read_data <= dmem_rdata
//    (0 for writes); dmem_req <= 0; -> IDLE. Without ack: MEM/WB loads bubble, counter++.
//  - Minimum memop occupancy: 2 cycles (ack in first ACCESS cycle).
//  - Counter reaches TIMEOUT without ack: bus_err <= 1, dmem_req <= 0, bubble, -> IDLE, mem_stall=0.
//  - Misaligned memop in IDLE: no request, no stall; align_err <= 1; MEM/WB loads bubble.
//  - pc_src = Branch & zero & (state==IDLE), combinational; branch_target = add_result.
//  - Sticky errors clear only on reset. Ack while IDLE is ignored.
// STRUCTURE
//  - Shared package mips_pkg: control-bit indices (M_BRANCH=2, M_READ=1, M_WRITE=0,
//    WB_REGWRITE=1, WB_MEMTOREG=0), state encoding IDLE=0/ACCESS=1.
//  - One sub-module: mem_wb_reg (MEM/WB latch with load-bubble input, async active-low reset).
//  - FSM, timeout counter, request latch and pc_src logic in this module.
// TESTING
//  1 ALU op (m=000, wb=10, alu=0x1234, dest=5) -> next edge wb_ctl=10, mem_alu_result=0x1234,
//    mem_write_reg=5, no stall.
//  2 Load addr 0x40, ack after 3 cycles with rdata 0xDEADBEEF -> dmem_req 3 cycles, mem_stall 3 cycles,
//    then read_data=0xDEADBEEF, wb_ctl=11; bubbles in between.
//  3 Store addr 0x80 data 0xCAFE, immediate ack -> dmem_we=1, addr=0x80, wdata=0xCAFE, 1 stall cycle.
//  4 Branch m=100, zero=1, add_result=0x200 -> pc_src=1, branch_target=0x200; zero=0 -> pc_src=0.
//  5 Load addr 0x42 -> no dmem_req, align_err=1, bubble; load with no ack -> after 15 cycles bus_err=1,
//    stall released.
//  6 reset=0 mid-ACCESS -> dmem_req/mem_stall 0 immediately, state IDLE, outputs 0.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : control-bit indices and MEM-stage state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_pkg;
  localparam int M_BRANCH    = 2;
  localparam int M_READ      = 1;
  localparam int M_WRITE     = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;
endpackage

`default_nettype wire

// File: rtl/mem_wb_reg.sv
// ============================================================================
// mem_wb_reg : MEM/WB pipeline latch; a bubble clears every field
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_wb_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bubble,
  input  logic [1:0]    wb_in,
  input  logic [DW-1:0] rdata_in,
  input  logic [DW-1:0] alu_in,
  input  logic [4:0]    dest_in,
  output logic [1:0]    wb_ctl,
  output logic [DW-1:0] read_data,
  output logic [DW-1:0] mem_alu_result,
  output logic [4:0]    mem_write_reg
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || bubble) begin
      wb_ctl         <= '0;
      read_data      <= '0;
      mem_alu_result <= '0;
      mem_write_reg  <= '0;
    end else begin
      wb_ctl         <= wb_in;
      read_data      <= rdata_in;
      mem_alu_result <= alu_in;
      mem_write_reg  <= dest_in;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// mem_access_stage : MIPS MEM stage with handshaked data-memory port,
// branch resolution and upstream stall while an access is outstanding. Rev 1.0
// ============================================================================
`default_nettype none

module mem_access_stage
  import mips_pkg::*;
#(
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    wb_ctlout,
  input  logic [2:0]    m_ctlout,
  input  logic [DW-1:0] alu_result,
  input  logic [DW-1:0] rdata2out,
  input  logic [DW-1:0] add_result,
  input  logic          zero,
  input  logic [4:0]    five_bit_muxout,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic          mem_stall,
  output logic          pc_src,
  output logic [DW-1:0] branch_target,
  output logic [1:0]    wb_ctl,
  output logic [DW-1:0] read_data,
  output logic [DW-1:0] mem_alu_result,
  output logic [4:0]    mem_write_reg,
  output logic          align_err,
  output logic          bus_err
);

  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  mem_state_t    state;
  logic [3:0]    cnt;
  logic [1:0]    lat_wb;
  logic [4:0]    lat_dest;
  logic          memop, aligned, to_hit;
  logic          bubble;
  logic [1:0]    nx_wb;
  logic [DW-1:0] nx_rdata, nx_alu;
  logic [4:0]    nx_dest;

  assign memop         = m_ctlout[M_READ] | m_ctlout[M_WRITE];
  assign aligned       = (alu_result[1:0] == 2'b00);
  assign to_hit        = (cnt == TO_LAST);
  assign branch_target = add_result;
  assign pc_src        = reset & m_ctlout[M_BRANCH] & zero & (state == IDLE);
  // The final ACCESS cycle (ack or abort) releases the pipeline so it advances in step with MEM/WB.
  assign mem_stall     = reset & (((state == IDLE) & memop & aligned) |
                                  ((state == ACCESS) & ~dmem_ack & ~to_hit));

  always_comb begin
    bubble   = 1'b0;
    nx_wb    = wb_ctlout;
    nx_rdata = '0;
    nx_alu   = alu_result;
    nx_dest  = five_bit_muxout;
    if (state == IDLE) begin
      bubble = memop;
    end else begin
      bubble   = ~dmem_ack;
      nx_wb    = lat_wb;
      nx_rdata = dmem_we ? '0 : dmem_rdata;
      nx_alu   = dmem_addr;
      nx_dest  = lat_dest;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      lat_wb     <= '0;
      lat_dest   <= '0;
      align_err  <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memop && aligned) begin
            state      <= ACCESS;
            cnt        <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= m_ctlout[M_WRITE];
            dmem_addr  <= {alu_result[DW-1:2], 2'b00};
            dmem_wdata <= rdata2out;
            lat_wb     <= wb_ctlout;
            lat_dest   <= five_bit_muxout;
          end else if (memop) begin
            align_err  <= 1'b1;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
          end else if (to_hit) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            bus_err  <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_wb_reg #(.DW(DW)) u_mem_wb (
    .clk            (clk),
    .reset          (reset),
    .bubble         (bubble),
    .wb_in          (nx_wb),
    .rdata_in       (nx_rdata),
    .alu_in         (nx_alu),
    .dest_in        (nx_dest),
    .wb_ctl         (wb_ctl),
    .read_data      (read_data),
    .mem_alu_result (mem_alu_result),
    .mem_write_reg  (mem_write_reg)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// tb_mem_access_stage : directed vectors and handshake sequences for mem_access_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic [31:0] alu_result, rdata2out, add_result;
  logic        zero;
  logic [4:0]  five_bit_muxout;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall, pc_src;
  logic [31:0] branch_target, read_data, mem_alu_result;
  logic [1:0]  wb_ctl;
  logic [4:0]  mem_write_reg;
  logic        align_err, bus_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DW(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout),
    .alu_result(alu_result), .rdata2out(rdata2out), .add_result(add_result),
    .zero(zero), .five_bit_muxout(five_bit_muxout), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .pc_src(pc_src), .branch_target(branch_target), .wb_ctl(wb_ctl),
    .read_data(read_data), .mem_alu_result(mem_alu_result),
    .mem_write_reg(mem_write_reg), .align_err(align_err), .bus_err(bus_err)
  );

  typedef struct {
    logic [2:0]  m;
    logic [1:0]  wb;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic        z;
    logic [31:0] add;
    logic        exp_pc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nop_inputs();
    m_ctlout = 3'b000; wb_ctlout = 2'b00; alu_result = 32'h0; rdata2out = 32'h0;
    add_result = 32'h0; zero = 1'b0; five_bit_muxout = 5'd0;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  // Issues one memory op and runs it to completion; ack_at counts ACCESS cycles from 1.
  task automatic run_mem(input logic [2:0] m, input logic [1:0] wb, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] dst, input int ack_at,
                         input logic [31:0] rdata, input logic exp_we,
                         output int nreq, output int nstall);
    bit done = 0;
    m_ctlout = m; wb_ctlout = wb; alu_result = addr; rdata2out = wdata; five_bit_muxout = dst;
    nreq = 0; nstall = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      dmem_ack   = (c == ack_at);
      dmem_rdata = (c == ack_at) ? rdata : 32'h0BAD_0BAD;
      #1;
      if (mem_stall) nstall++;
      if (dmem_req)  nreq++;
      if (c == 1) begin
        chk("acc_addr", dmem_addr, addr);
        chk("acc_we", {31'b0, dmem_we}, {31'b0, exp_we});
        if (exp_we) chk("acc_wdata", dmem_wdata, wdata);
      end
      if (c >= 1) chk("acc_bubble_wb", {30'b0, wb_ctl}, 32'd0);
      if (c >= 1 && !mem_stall) done = 1;
      edge1();
    end
    if (!done) chk("mem_op_bound", 32'd0, 32'd1);
    dmem_ack = 1'b0;
    nop_inputs();
  endtask

  vec_t vecs[5];
  int nreq, nstall;

  initial begin
    vecs[0] = '{m:3'b000, wb:2'b10, alu:32'h1234,      dest:5'd5,  z:1'b0, add:32'h0,   exp_pc:1'b0};
    vecs[1] = '{m:3'b100, wb:2'b00, alu:32'h0,         dest:5'd0,  z:1'b1, add:32'h200, exp_pc:1'b1};
    vecs[2] = '{m:3'b100, wb:2'b00, alu:32'h4,         dest:5'd0,  z:1'b0, add:32'h200, exp_pc:1'b0};
    vecs[3] = '{m:3'b000, wb:2'b11, alu:32'hFFFF_FFFF, dest:5'd31, z:1'b1, add:32'h44,  exp_pc:1'b0};
    vecs[4] = '{m:3'b100, wb:2'b01, alu:32'h8,         dest:5'd9,  z:1'b1, add:32'hABC, exp_pc:1'b1};

    reset = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    nop_inputs();
    repeat (2) @(posedge clk);
    #3;
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_wb", {30'b0, wb_ctl}, 32'd0);
    chk("rst_errs", {30'b0, align_err, bus_err}, 32'd0);
    reset = 1'b1;
    edge1();

    // Non-memory ops: 1-cycle MEM/WB latency, combinational pc_src
    for (int i = 0; i < 5; i++) begin
      m_ctlout = vecs[i].m; wb_ctlout = vecs[i].wb; alu_result = vecs[i].alu;
      five_bit_muxout = vecs[i].dest; zero = vecs[i].z; add_result = vecs[i].add;
      #1;
      chk("vec_pc_src", {31'b0, pc_src}, {31'b0, vecs[i].exp_pc});
      chk("vec_target", branch_target, vecs[i].add);
      chk("vec_stall", {31'b0, mem_stall}, 32'd0);
      edge1();
      chk("vec_wb", {30'b0, wb_ctl}, {30'b0, vecs[i].wb});
      chk("vec_alu", mem_alu_result, vecs[i].alu);
      chk("vec_dest", {27'b0, mem_write_reg}, {27'b0, vecs[i].dest});
      chk("vec_rdata", read_data, 32'd0);
    end
    nop_inputs();

    // Load with ack on the third ACCESS cycle
    run_mem(3'b010, 2'b11, 32'h40, 32'h0, 5'd7, 3, 32'hDEAD_BEEF, 1'b0, nreq, nstall);
    chk("ld_req_cycles", nreq, 32'd3);
    chk("ld_stall_cycles", nstall, 32'd3);
    chk("ld_wb", {30'b0, wb_ctl}, 32'd3);
    chk("ld_rdata", read_data, 32'hDEAD_BEEF);
    chk("ld_alu", mem_alu_result, 32'h40);
    chk("ld_dest", {27'b0, mem_write_reg}, 32'd7);
    chk("ld_req_drop", {31'b0, dmem_req}, 32'd0);

    // Store with immediate ack
    run_mem(3'b001, 2'b00, 32'h80, 32'hCAFE, 5'd3, 1, 32'h0, 1'b1, nreq, nstall);
    chk("st_req_cycles", nreq, 32'd1);
    chk("st_stall_cycles", nstall, 32'd1);
    chk("st_rdata", read_data, 32'd0);

    // Read and write both set behaves as a write
    run_mem(3'b011, 2'b10, 32'hC4, 32'h55AA, 5'd4, 1, 32'h1111_2222, 1'b1, nreq, nstall);
    chk("rw_rdata", read_data, 32'd0);
    chk("rw_wb", {30'b0, wb_ctl}, 32'd2);

    // Ack while idle is ignored
    wb_ctlout = 2'b10; alu_result = 32'h99; five_bit_muxout = 5'd2;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    edge1();
    dmem_ack = 1'b0;
    chk("idle_ack_req", {31'b0, dmem_req}, 32'd0);
    chk("idle_ack_rdata", read_data, 32'd0);
    chk("idle_ack_alu", mem_alu_result, 32'h99);
    nop_inputs();

    // Misaligned load: no request, no stall, sticky align_err, bubble
    m_ctlout = 3'b010; wb_ctlout = 2'b11; alu_result = 32'h42; five_bit_muxout = 5'd6;
    #1;
    chk("mis_stall", {31'b0, mem_stall}, 32'd0);
    edge1();
    chk("mis_req", {31'b0, dmem_req}, 32'd0);
    chk("mis_align_err", {31'b0, align_err}, 32'd1);
    chk("mis_wb", {30'b0, wb_ctl}, 32'd0);
    nop_inputs();
    edge1();
    chk("align_sticky", {31'b0, align_err}, 32'd1);

    // Load never acknowledged: abort after 15 ACCESS cycles
    run_mem(3'b010, 2'b11, 32'h100, 32'h0, 5'd8, -1, 32'h0, 1'b0, nreq, nstall);
    chk("to_req_cycles", nreq, 32'd15);
    chk("to_stall_cycles", nstall, 32'd15);
    chk("to_bus_err", {31'b0, bus_err}, 32'd1);
    chk("to_req_drop", {31'b0, dmem_req}, 32'd0);
    chk("to_wb_bubble", {30'b0, wb_ctl}, 32'd0);
    #1;
    chk("to_stall_rel", {31'b0, mem_stall}, 32'd0);

    // Asynchronous reset in the middle of an access
    m_ctlout = 3'b010; wb_ctlout = 2'b11; alu_result = 32'h200; five_bit_muxout = 5'd1;
    edge1();
    #1;
    chk("mid_req_up", {31'b0, dmem_req}, 32'd1);
    chk("mid_stall_up", {31'b0, mem_stall}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("ar_req", {31'b0, dmem_req}, 32'd0);
    chk("ar_stall", {31'b0, mem_stall}, 32'd0);
    chk("ar_errs", {30'b0, align_err, bus_err}, 32'd0);
    chk("ar_addr", dmem_addr, 32'd0);
    chk("ar_wb", {30'b0, wb_ctl}, 32'd0);
    nop_inputs();
    #2 reset = 1'b1;
    edge1();
    chk("post_rst_req", {31'b0, dmem_req}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
